id_exe_stage_reg: RTL

//  - Pipeline register between ID and EXE. Captures the decoded control bundle
//    (EXE_CMD, S, B, MEM_W_EN, MEM_R_EN, WB_EN), operands and the destination field.
//  - Hazard unit freezes it; branch resolution in EXE flushes it.
//  - Produces a VALID qualifier and a saturating bubble counter for debug.

---
 rtl/id_exe_stage_reg.sv | 124 ++++++++++++
 1 files changed

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register: freeze holds, flush inserts a bubble, saturating bubble count.
// Optional ID_EXE_FORWARD_EN adds SRC1/SRC2 register fields for the forwarding unit.
module id_exe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              FREEZE,
    input  logic              FLUSH,
    input  logic [DATA_W-1:0] PC_IN,
    input  logic [DATA_W-1:0] VAL_RN_IN,
    input  logic [DATA_W-1:0] VAL_RM_IN,
    input  logic              IMM_IN,
    input  logic [11:0]       SHIFT_OPERAND_IN,
    input  logic [23:0]       SIGNED_IMM24_IN,
    input  logic [3:0]        DEST_IN,
    input  logic [3:0]        STATUS_IN,
    input  logic [3:0]        EXE_CMD_IN,
    input  logic              S_IN,
    input  logic              B_IN,
    input  logic              MEM_W_EN_IN,
    input  logic              MEM_R_EN_IN,
    input  logic              WB_EN_IN,
`ifdef ID_EXE_FORWARD_EN
    input  logic [3:0]        SRC1_IN,
    input  logic [3:0]        SRC2_IN,
    output logic [3:0]        SRC1_OUT,
    output logic [3:0]        SRC2_OUT,
`endif
    output logic [DATA_W-1:0] PC_OUT,
    output logic [DATA_W-1:0] VAL_RN_OUT,
    output logic [DATA_W-1:0] VAL_RM_OUT,
    output logic              IMM_OUT,
    output logic [11:0]       SHIFT_OPERAND_OUT,
    output logic [23:0]       SIGNED_IMM24_OUT,
    output logic [3:0]        DEST_OUT,
    output logic [3:0]        STATUS_OUT,
    output logic [3:0]        EXE_CMD_OUT,
    output logic              S_OUT,
    output logic              B_OUT,
    output logic              MEM_W_EN_OUT,
    output logic              MEM_R_EN_OUT,
    output logic              WB_EN_OUT,
    output logic              VALID_OUT,
    output logic [CNT_W-1:0]  BUBBLE_CNT
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic load_data;
    logic load_ctrl;

    // Data fields load on flush as well; they are don't-care while VALID_OUT=0.
    assign load_data = FLUSH || !FREEZE;
    assign load_ctrl = !FLUSH && !FREEZE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            PC_OUT            <= '0;
            VAL_RN_OUT        <= '0;
            VAL_RM_OUT        <= '0;
            IMM_OUT           <= 1'b0;
            SHIFT_OPERAND_OUT <= '0;
            SIGNED_IMM24_OUT  <= '0;
            DEST_OUT          <= '0;
            STATUS_OUT        <= '0;
        end else if (load_data) begin
            PC_OUT            <= PC_IN;
            VAL_RN_OUT        <= VAL_RN_IN;
            VAL_RM_OUT        <= VAL_RM_IN;
            IMM_OUT           <= IMM_IN;
            SHIFT_OPERAND_OUT <= SHIFT_OPERAND_IN;
            SIGNED_IMM24_OUT  <= SIGNED_IMM24_IN;
            DEST_OUT          <= DEST_IN;
            STATUS_OUT        <= STATUS_IN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || FLUSH) begin
            EXE_CMD_OUT  <= '0;
            S_OUT        <= 1'b0;
            B_OUT        <= 1'b0;
            MEM_W_EN_OUT <= 1'b0;
            MEM_R_EN_OUT <= 1'b0;
            WB_EN_OUT    <= 1'b0;
            VALID_OUT    <= 1'b0;
        end else if (load_ctrl) begin
            EXE_CMD_OUT  <= EXE_CMD_IN;
            S_OUT        <= S_IN;
            B_OUT        <= B_IN;
            MEM_W_EN_OUT <= MEM_W_EN_IN;
            MEM_R_EN_OUT <= MEM_R_EN_IN;
            WB_EN_OUT    <= WB_EN_IN;
            VALID_OUT    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            BUBBLE_CNT <= '0;
        end else if (FLUSH && (BUBBLE_CNT != CNT_MAX)) begin
            BUBBLE_CNT <= BUBBLE_CNT + CNT_W'(1);
        end
    end

`ifdef ID_EXE_FORWARD_EN
    // A bubble carries register 15 so the forwarding unit never matches it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            SRC1_OUT <= '0;
            SRC2_OUT <= '0;
        end else if (FLUSH) begin
            SRC1_OUT <= 4'hF;
            SRC2_OUT <= 4'hF;
        end else if (!FREEZE) begin
            SRC1_OUT <= SRC1_IN;
            SRC2_OUT <= SRC2_IN;
        end
    end
`endif

endmodule
